// File: rtl/relax_pkg.sv
// Shared constants and helpers for the Bellman-Ford edge relaxation pipeline.
// Field helpers take widths as arguments, so any parameterisation up to 64 bits can use them.
package relax_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  // Round-tracking operation, encoded as {round_clr, output handshake}.
  typedef enum logic [1:0] {
    TRK_IDLE    = 2'b00,
    TRK_ACCUM   = 2'b01,
    TRK_CLEAR   = 2'b10,
    TRK_RESTART = 2'b11
  } trk_op_e;

  function automatic wide_t ones(input int unsigned w);
    return (w >= MAX_W) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
  endfunction

  // All-ones distance marks an unreachable vertex.
  function automatic wide_t inf_of(input int unsigned dist_w);
    return ones(dist_w);
  endfunction

  function automatic wide_t get_dist(input wide_t word, input int unsigned dist_w);
    return word & ones(dist_w);
  endfunction

  function automatic wide_t get_pred(input wide_t word, input int unsigned dist_w,
                                     input int unsigned vidx_w);
    return (word >> dist_w) & ones(vidx_w);
  endfunction

  function automatic int unsigned popcount(input wide_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/relax_lane.sv
// One relaxation lane: saturate the candidate distance, compare against the
// current destination distance and select the word to write back.
module relax_lane
  import relax_pkg::*;
#(
  parameter int VIDX_W = 7,
  parameter int DIST_W = 25
) (
  input  logic                     edge_vld_i,
  input  logic                     src_inf_i,
  input  logic [DIST_W:0]          sum_i,
  input  logic [VIDX_W-1:0]        src_i,
  input  logic [VIDX_W+DIST_W-1:0] dv_i,
  output logic [VIDX_W+DIST_W-1:0] dv_o,
  output logic                     upd_o
);

  localparam int VW = VIDX_W + DIST_W;
  localparam logic [DIST_W-1:0] INF    = DIST_W'(inf_of(DIST_W));
  localparam logic [DIST_W-1:0] INF_M1 = INF - DIST_W'(1);

  logic [DIST_W-1:0] sat;
  logic [DIST_W-1:0] dst_dist;

  // A finite path never reports INF; it clamps to the largest reachable distance.
  assign sat      = (sum_i >= {1'b0, INF}) ? INF_M1 : sum_i[DIST_W-1:0];
  assign dst_dist = DIST_W'(get_dist(wide_t'(dv_i), DIST_W));

  // Strictly smaller only: equal distances keep the old predecessor.
  assign upd_o = edge_vld_i && !src_inf_i && (sat < dst_dist);
  assign dv_o  = upd_o ? {src_i, sat} : dv_i;

endmodule

// File: rtl/relax_pipe.sv
// Two-stage pipelined Bellman-Ford edge relaxer with valid/ready flow control
// and per-round convergence tracking (sticky changed flag, saturating counter).
module relax_pipe
  import relax_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int VIDX_W = 7,
  parameter int DIST_W = 25,
  parameter int EDGE_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*VIDX_W-1:0]           s,
  input  logic [LANES*EDGE_W-1:0]           e,
  input  logic [LANES*(VIDX_W+DIST_W)-1:0]  sv,
  input  logic [LANES*(VIDX_W+DIST_W)-1:0]  dv,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*(VIDX_W+DIST_W)-1:0]  o_dv,
  output logic [LANES-1:0]                  update_mask,
  input  logic                              round_clr,
  output logic                              changed,
  output logic [CNT_W-1:0]                  update_cnt
);

  localparam int VW = VIDX_W + DIST_W;
  localparam int AW = CNT_W + 33;
  localparam logic [DIST_W-1:0] INF     = DIST_W'(inf_of(DIST_W));
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic adv1, adv2, in_hs, out_hs;
  logic s1_valid_q;
  logic out_valid_q;
  logic [LANES*VW-1:0] o_dv_q;
  logic [LANES-1:0]    mask_q;
  logic [LANES*VW-1:0] lane_dv;
  logic [LANES-1:0]    lane_upd;

  // Stage 2 advances when it is empty or being drained; stage 1 when stage 2 can take it.
  assign adv2   = !out_valid_q || out_ready;
  assign adv1   = !s1_valid_q || adv2;
  assign in_hs  = in_valid && adv1;
  assign out_hs = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [EDGE_W-1:0] edge_w;
      logic [VW-1:0]     sv_w;
      logic [DIST_W-1:0] weight;
      logic [DIST_W-1:0] sv_dist;
      logic [DIST_W:0]   sum_q;
      logic [VW-1:0]     dv_q;
      logic [VIDX_W-1:0] src_q;
      logic              ev_q;
      logic              inf_q;

      assign edge_w  = e[gi*EDGE_W +: EDGE_W];
      assign sv_w    = sv[gi*VW +: VW];
      assign weight  = DIST_W'(get_dist(wide_t'(edge_w), DIST_W));
      assign sv_dist = DIST_W'(get_dist(wide_t'(sv_w), DIST_W));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sum_q <= '0;
          dv_q  <= '0;
          src_q <= '0;
          ev_q  <= 1'b0;
          inf_q <= 1'b0;
        end else if (in_hs) begin
          // One extra bit keeps the raw sum exact so stage 2 can saturate it.
          sum_q <= {1'b0, weight} + {1'b0, sv_dist};
          dv_q  <= dv[gi*VW +: VW];
          src_q <= s[gi*VIDX_W +: VIDX_W];
          ev_q  <= edge_w[EDGE_W-1];
          inf_q <= (sv_dist == INF);
        end
      end

      relax_lane #(
        .VIDX_W (VIDX_W),
        .DIST_W (DIST_W)
      ) u_lane (
        .edge_vld_i (ev_q),
        .src_inf_i  (inf_q),
        .sum_i      (sum_q),
        .src_i      (src_q),
        .dv_i       (dv_q),
        .dv_o       (lane_dv[gi*VW +: VW]),
        .upd_o      (lane_upd[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      o_dv_q      <= '0;
      mask_q      <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        o_dv_q <= lane_dv;
        mask_q <= lane_upd;
      end
    end
  end

  trk_op_e           trk_op;
  int unsigned       beat_k;
  logic [CNT_W-1:0]  cnt_base;
  logic              chg_base;
  logic [AW-1:0]     cnt_sum;
  logic [CNT_W-1:0]  update_cnt_q, update_cnt_d;
  logic              changed_q, changed_d;

  always_comb begin
    trk_op       = trk_op_e'({round_clr, out_hs});
    beat_k       = popcount(wide_t'(mask_q));
    cnt_base     = update_cnt_q;
    chg_base     = changed_q;
    // A beat retiring together with round_clr is counted in the new round.
    if (trk_op == TRK_CLEAR || trk_op == TRK_RESTART) begin
      cnt_base = '0;
      chg_base = 1'b0;
    end
    cnt_sum      = AW'(cnt_base) + AW'(beat_k);
    update_cnt_d = cnt_base;
    changed_d    = chg_base;
    if (trk_op == TRK_ACCUM || trk_op == TRK_RESTART) begin
      update_cnt_d = (cnt_sum > AW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
      changed_d    = chg_base || (beat_k != 0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update_cnt_q <= '0;
      changed_q    <= 1'b0;
    end else begin
      update_cnt_q <= update_cnt_d;
      changed_q    <= changed_d;
    end
  end

  assign in_ready    = adv1;
  assign out_valid   = out_valid_q;
  assign o_dv        = o_dv_q;
  assign update_mask = mask_q;
  assign changed     = changed_q;
  assign update_cnt  = update_cnt_q;

endmodule

// File: tb/tb_relax_pipe.sv
// Randomised and directed checks of relax_pipe against a queue-based reference
// model; a second instance with a 3-bit counter covers counter saturation.
module tb_relax_pipe;

  localparam int LANES  = 4;
  localparam int VIDX_W = 7;
  localparam int DIST_W = 25;
  localparam int EDGE_W = 32;
  localparam int CNT_W  = 16;
  localparam int VW     = VIDX_W + DIST_W;
  localparam longint INF     = (longint'(1) << DIST_W) - 1;
  localparam int     CMAX    = (1 << CNT_W) - 1;
  localparam int     CMAX3   = 7;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, out_ready, round_clr;
  logic in_ready, out_valid, changed;
  logic [LANES*VIDX_W-1:0] s;
  logic [LANES*EDGE_W-1:0] e;
  logic [LANES*VW-1:0]     sv, dv, o_dv;
  logic [LANES-1:0]        update_mask;
  logic [CNT_W-1:0]        update_cnt;

  logic                in_ready3, out_valid3, changed3;
  logic [LANES*VW-1:0] o_dv3;
  logic [LANES-1:0]    update_mask3;
  logic [2:0]          update_cnt3;

  always #5 clk = ~clk;

  relax_pipe #(.LANES(LANES), .VIDX_W(VIDX_W), .DIST_W(DIST_W), .EDGE_W(EDGE_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .e(e), .sv(sv), .dv(dv), .out_valid(out_valid), .out_ready(out_ready),
    .o_dv(o_dv), .update_mask(update_mask), .round_clr(round_clr),
    .changed(changed), .update_cnt(update_cnt));

  relax_pipe #(.LANES(LANES), .VIDX_W(VIDX_W), .DIST_W(DIST_W), .EDGE_W(EDGE_W), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
    .s(s), .e(e), .sv(sv), .dv(dv), .out_valid(out_valid3), .out_ready(out_ready),
    .o_dv(o_dv3), .update_mask(update_mask3), .round_clr(round_clr),
    .changed(changed3), .update_cnt(update_cnt3));

  int n_checks = 0;
  int n_fail   = 0;
  int n_delivered = 0;

  logic [LANES*VW-1:0] exp_q[$];
  logic [LANES-1:0]    expm_q[$];
  int  cnt_m = 0, cnt3_m = 0;
  bit  chg_m = 0;
  bit  stalled = 0;
  logic [LANES*VW-1:0] held_dv;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the relaxation rule.
  function automatic void model_lane(input logic [EDGE_W-1:0] ew, input logic [VW-1:0] svw,
                                     input logic [VW-1:0] dvw, input logic [VIDX_W-1:0] src,
                                     output logic [VW-1:0] o, output logic upd);
    longint w, sd, dd, c;
    w  = longint'(ew[DIST_W-1:0]);
    sd = longint'(svw[DIST_W-1:0]);
    dd = longint'(dvw[DIST_W-1:0]);
    c  = w + sd;
    if (c >= INF) c = INF - 1;
    upd = ew[EDGE_W-1] && (sd != INF) && (c < dd);
    o   = upd ? {src, c[DIST_W-1:0]} : dvw;
  endfunction

  task automatic set_lane(input int i, input bit ev, input longint w, input longint sd,
                          input longint dd, input int src);
    e[i*EDGE_W +: EDGE_W] = {ev, 6'($urandom), DIST_W'(w)};
    sv[i*VW +: VW]        = {VIDX_W'($urandom), DIST_W'(sd)};
    dv[i*VW +: VW]        = {VIDX_W'($urandom), DIST_W'(dd)};
    s[i*VIDX_W +: VIDX_W] = VIDX_W'(src);
  endtask

  function automatic longint rand_dist();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return INF;
    if (r == 1) return INF - 1;
    if (r == 2) return longint'($urandom_range(0, 15));
    return longint'($urandom_range(0, 1 << 24));
  endfunction

  task automatic rand_beat();
    for (int i = 0; i < LANES; i++)
      set_lane(i, $urandom_range(0, 3) != 0, rand_dist(), rand_dist(), rand_dist(),
               $urandom_range(0, 127));
  endtask

  task automatic full_beat(input int nupd);
    for (int i = 0; i < LANES; i++)
      set_lane(i, i < nupd, $urandom_range(0, 100), $urandom_range(0, 100),
               1000 + $urandom_range(0, 5000), $urandom_range(0, 127));
  endtask

  // One clock cycle: called just after a falling edge with inputs already driven.
  task automatic step(output bit acc);
    bit out_hs;
    int k;
    logic [LANES*VW-1:0] ob;
    logic [LANES-1:0]    mb;
    logic [VW-1:0]       ol;
    logic                ul;
    #1;
    chk("in_ready", in_ready, (exp_q.size() >= 2 && !out_ready) ? 1'b0 : 1'b1);
    if (stalled) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_hold", o_dv, held_dv);
    end
    if (out_valid && exp_q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
    acc    = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    k = 0;
    if (out_hs && exp_q.size() != 0) begin
      chk("o_dv", o_dv, exp_q[0]);
      chk("update_mask", update_mask, expm_q[0]);
      k = $countones(expm_q[0]);
      $display("beat %0d: o_dv=%h mask=%b", n_delivered, o_dv, update_mask);
      void'(exp_q.pop_front());
      void'(expm_q.pop_front());
      n_delivered++;
    end
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        model_lane(e[i*EDGE_W +: EDGE_W], sv[i*VW +: VW], dv[i*VW +: VW],
                   s[i*VIDX_W +: VIDX_W], ol, ul);
        ob[i*VW +: VW] = ol;
        mb[i] = ul;
      end
      exp_q.push_back(ob);
      expm_q.push_back(mb);
    end
    if (round_clr) begin
      cnt_m = 0; cnt3_m = 0; chg_m = 0;
    end
    if (out_hs) begin
      cnt_m  = (cnt_m + k > CMAX) ? CMAX : cnt_m + k;
      cnt3_m = (cnt3_m + k > CMAX3) ? CMAX3 : cnt3_m + k;
      if (k > 0) chg_m = 1;
    end
    stalled = out_valid && !out_ready;
    held_dv = o_dv;
    @(posedge clk);
    #1;
    chk("changed", changed, chg_m);
    chk("update_cnt", update_cnt, cnt_m);
    chk("changed_w3", changed3, chg_m);
    chk("update_cnt_w3", update_cnt3, cnt3_m);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 0; out_ready = 1; round_clr = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(acc);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit acc, seen_block;
    int sent, base;
    reset_n = 0; in_valid = 0; out_ready = 1; round_clr = 0;
    s = '0; e = '0; sv = '0; dv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_o_dv", o_dv, '0);
    chk("rst_mask", update_mask, '0);
    chk("rst_changed", changed, 1'b0);
    chk("rst_cnt", update_cnt, '0);
    @(negedge clk);
    reset_n = 1;

    // Basic relax on lane 0 with two-cycle latency.
    rand_beat();
    for (int i = 1; i < LANES; i++) e[i*EDGE_W + EDGE_W - 1] = 1'b0;
    set_lane(0, 1, 5, 10, 20, 3);
    in_valid = 1;
    step(acc);
    chk("basic_accept", acc, 1'b1);
    in_valid = 0;
    #1 chk("lat_cycle1", out_valid, 1'b0);
    step(acc);
    #1 chk("lat_cycle2", out_valid, 1'b1);
    chk("basic_lane0", o_dv[0 +: VW], {7'd3, 25'd15});
    chk("basic_mask", update_mask, 4'b0001);
    step(acc);
    chk("basic_changed", changed, 1'b1);
    chk("basic_cnt", update_cnt, 1);

    // New round, then lanes that must not update.
    round_clr = 1; step(acc); round_clr = 0;
    set_lane(0, 0, 1, 1, 100, 9);
    set_lane(1, 1, 5, 15, 20, 9);
    set_lane(2, 0, 0, 1, 100, 9);
    set_lane(3, 1, 1, INF, 100, 9);
    in_valid = 1; step(acc); in_valid = 0;
    step(acc); step(acc);
    chk("noupd_changed", changed, 1'b0);

    // Saturation: clamped sum beats INF but ties with INF-1.
    rand_beat();
    set_lane(0, 1, INF - 1, INF - 1, INF, 4);
    set_lane(1, 1, INF - 1, INF - 1, INF - 1, 4);
    in_valid = 1; step(acc); in_valid = 0;
    step(acc);
    chk("sat_lane0", o_dv[DIST_W-1:0], INF - 1);
    chk("sat_mask01", update_mask[1:0], 2'b01);
    drain();

    // Backpressure: out_ready low for cycles 3-6.
    base = n_delivered; sent = 0; seen_block = 0;
    rand_beat();
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 3 && i <= 6);
      in_valid  = (sent < 5);
      #0;
      step(acc);
      if (in_valid && !acc) seen_block = 1;
      if (acc) begin sent++; rand_beat(); end
    end
    drain();
    chk("bp_blocked", seen_block, 1'b1);
    chk("bp_delivered", n_delivered - base, 5);

    // Round tracking: 3 full beats, then round_clr with a 2-update beat retiring.
    round_clr = 1; step(acc); round_clr = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4);
      if (i < 3) full_beat(4); else full_beat(2);
      round_clr = (i == 5);
      step(acc);
      if (i == 3) chk("sat_cnt_w3", update_cnt3, 7);
      if (i == 4) chk("round_cnt12", update_cnt, 12);
      if (i == 5) begin
        chk("round_cnt2", update_cnt, 2);
        chk("round_changed", changed, 1'b1);
      end
    end
    round_clr = 0;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      round_clr = ($urandom_range(0, 19) == 0);
      step(acc);
    end
    round_clr = 0;

    // Asynchronous reset between clock edges with beats in flight.
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin rand_beat(); step(acc); end
    #2 reset_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_changed", changed, 1'b0);
    chk("arst_cnt", update_cnt, '0);
    exp_q.delete(); expm_q.delete();
    cnt_m = 0; cnt3_m = 0; chg_m = 0; stalled = 0;
    in_valid = 0;
    @(negedge clk);
    reset_n = 1;
    rand_beat();
    in_valid = 1; step(acc); in_valid = 0;
    chk("post_rst_accept", acc, 1'b1);
    #1 chk("post_rst_lat1", out_valid, 1'b0);
    step(acc);
    #1 chk("post_rst_lat2", out_valid, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
